multdiv_issue_unit: RTL and testbench



---
 rtl/multdiv_pkg.sv | 27 ++
 rtl/multdiv_datapath.sv | 115 +++++++++++
 rtl/multdiv_issue_unit.sv | 123 ++++++++++++
 tb/tb_multdiv_issue_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the register
// decoder used by the stall logic.
package multdiv_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 27;
  localparam int RD_HI     = 26;
  localparam int RD_LO     = 22;
  localparam int RS_HI     = 21;
  localparam int RS_LO     = 17;
  localparam int RT_HI     = 16;
  localparam int RT_LO     = 12;
  localparam int ALUOP_HI  = 6;
  localparam int ALUOP_LO  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/multdiv_datapath.sv
// Magnitude shift-add multiplier and restoring divider with the sign/overflow
// fix-up computed combinationally from the final iteration state.
module multdiv_datapath #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             load_is_div,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic             step,
  output logic             last_iter,
  output logic [WIDTH-1:0] fix_data,
  output logic             fix_exception
);

  localparam int CW = $clog2(ITER);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [CW-1:0]      counter_q, counter_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shifted;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   quot_signed;
  logic               mul_exc, div_exc;

  assign mag_a = load_a[WIDTH-1] ? -load_a : load_a;
  assign mag_b = load_b[WIDTH-1] ? -load_b : load_b;

  // The multiplier sits in the low half of acc and is consumed LSB first.
  assign mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign div_shifted = {rem_q, quot_q[WIDTH-1]};
  assign div_diff    = div_shifted - {1'b0, divisor_q};

  always_comb begin
    acc_d     = acc_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    mcand_d   = mcand_q;
    divisor_d = divisor_q;
    counter_d = counter_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    if (load) begin
      acc_d     = {{WIDTH{1'b0}}, mag_b};
      rem_d     = '0;
      quot_d    = mag_a;
      mcand_d   = mag_a;
      divisor_d = mag_b;
      counter_d = '0;
      is_div_d  = load_is_div;
      neg_d     = load_a[WIDTH-1] ^ load_b[WIDTH-1];
    end else if (step) begin
      acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
      counter_d = counter_q + CW'(1);
      if (!div_diff[WIDTH]) begin
        rem_d  = div_diff[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = div_shifted[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      mcand_q   <= '0;
      divisor_q <= '0;
      counter_q <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      mcand_q   <= mcand_d;
      divisor_q <= divisor_d;
      counter_q <= counter_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
    end
  end

  assign last_iter = (counter_q == CW'(ITER - 1));

  // A product fits only if its top WIDTH+1 bits are pure sign extension.
  assign prod_signed = neg_q ? -acc_q : acc_q;
  assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
  assign mul_exc     = !((&prod_top) || !(|prod_top));

  // A positive quotient magnitude of 2^(WIDTH-1) only arises from MIN / -1.
  assign quot_signed = neg_q ? -quot_q : quot_q;
  assign div_exc     = !neg_q && quot_q[WIDTH-1];

  assign fix_exception = is_div_q ? div_exc : mul_exc;
  assign fix_data      = fix_exception ? '0 :
                         (is_div_q ? quot_signed : prod_signed[WIDTH-1:0]);

endmodule

// File: rtl/multdiv_issue_unit.sv
// Issue/handshake wrapper: decodes mul/div, sequences the iterative datapath and
// holds the result for writeback until it is acknowledged.
module multdiv_issue_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_instruction,
  input  logic [WIDTH-1:0] in_operand_A,
  input  logic [WIDTH-1:0] in_operand_B,
  output logic             in_ready,
  output logic             busy,
  output logic [31:0]      inflight_instruction,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_data,
  output logic [4:0]       result_regD,
  output logic             result_exception,
  input  logic             result_ack
);

  import multdiv_pkg::*;

  md_state_e        state_q, state_d;
  logic [31:0]      inflight_q, inflight_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [4:0]       regd_q, regd_d;
  logic             exc_q, exc_d;

  logic [4:0]       dec_opcode, dec_aluop, dec_rd;
  logic             dec_mul, dec_div, accept, div_by_zero, step;
  logic             last_iter, fix_exception;
  logic [WIDTH-1:0] fix_data;

  assign dec_opcode = in_instruction[OPCODE_HI:OPCODE_LO];
  assign dec_aluop  = in_instruction[ALUOP_HI:ALUOP_LO];
  assign dec_rd     = in_instruction[RD_HI:RD_LO];
  assign dec_mul    = (dec_opcode == OP_RTYPE) && (dec_aluop == ALU_MUL);
  assign dec_div    = (dec_opcode == OP_RTYPE) && (dec_aluop == ALU_DIV);

  assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && result_ack);
  assign accept      = in_valid && in_ready && (dec_mul || dec_div);
  assign div_by_zero = dec_div && (in_operand_B == '0);

  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    data_d     = data_q;
    regd_d     = regd_q;
    exc_d      = exc_q;
    step       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          inflight_d = in_instruction;
          if (div_by_zero) begin
            state_d = ST_DONE;
            data_d  = '0;
            regd_d  = dec_rd;
            exc_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else if ((state_q == ST_DONE) && result_ack) begin
          state_d    = ST_IDLE;
          inflight_d = '0;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_iter) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        data_d  = fix_data;
        regd_d  = inflight_q[RD_HI:RD_LO];
        exc_d   = fix_exception;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inflight_q <= '0;
      data_q     <= '0;
      regd_q     <= '0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      data_q     <= data_d;
      regd_q     <= regd_d;
      exc_q      <= exc_d;
    end
  end

  multdiv_datapath #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_datapath (
    .clock         (clock),
    .reset         (reset),
    .load          (accept),
    .load_is_div   (dec_div),
    .load_a        (in_operand_A),
    .load_b        (in_operand_B),
    .step          (step),
    .last_iter     (last_iter),
    .fix_data      (fix_data),
    .fix_exception (fix_exception)
  );

  assign busy                 = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign result_valid         = (state_q == ST_DONE);
  assign inflight_instruction = inflight_q;
  assign result_data          = data_q;
  assign result_regD          = regd_q;
  assign result_exception     = exc_q;

endmodule

// File: tb/tb_multdiv_issue_unit.sv
// Directed bench for multdiv_issue_unit: a vector table of mul/div cases plus
// hand-written back-to-back, reset-abort and illegal-decode sequences.
module tb_multdiv_issue_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic [31:0] in_operand_A;
  logic [31:0] in_operand_B;
  logic        in_ready;
  logic        busy;
  logic [31:0] inflight_instruction;
  logic        result_valid;
  logic [31:0] result_data;
  logic [4:0]  result_regD;
  logic        result_exception;
  logic        result_ack;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[14];

  multdiv_issue_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock                (clock),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_instruction       (in_instruction),
    .in_operand_A         (in_operand_A),
    .in_operand_B         (in_operand_B),
    .in_ready             (in_ready),
    .busy                 (busy),
    .inflight_instruction (inflight_instruction),
    .result_valid         (result_valid),
    .result_data          (result_data),
    .result_regD          (result_regD),
    .result_exception     (result_exception),
    .result_ack           (result_ack)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mk_instr(input logic [4:0] opcode, input logic [4:0] rd,
                                           input logic [4:0] aluop);
    logic [31:0] w;
    w = {opcode, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
    return w;
  endfunction

  function automatic logic [31:0] op_instr(input logic is_div, input logic [4:0] rd);
    return mk_instr(5'b00000, rd, is_div ? 5'b00111 : 5'b00110);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called at a falling edge; returns just after the acceptance edge with operands scrambled.
  task automatic applyStimulus(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    in_valid       = 1'b1;
    in_instruction = op_instr(is_div, rd);
    in_operand_A   = a;
    in_operand_B   = b;
    @(posedge clock);
    #1;
    in_valid       = 1'b0;
    in_instruction = $urandom;
    in_operand_A   = $urandom;
    in_operand_B   = $urandom;
  endtask

  task automatic waitValid(output bit got, output int lat, output int busy_cycles);
    got = 1'b0;
    lat = 0;
    busy_cycles = 0;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(negedge clock);
      if (result_valid) begin
        got = 1'b1;
        lat = n;
      end else if (busy) begin
        busy_cycles++;
      end
    end
  endtask

  task automatic ackResult(input string tag);
    result_ack = 1'b1;
    @(posedge clock);
    #1;
    result_ack = 1'b0;
    @(negedge clock);
    checkOutput($sformatf("%s ack valid", tag), {31'b0, result_valid}, 32'd0);
    checkOutput($sformatf("%s ack ready", tag), {31'b0, in_ready}, 32'd1);
    checkOutput($sformatf("%s ack inflight", tag), inflight_instruction, 32'h0);
  endtask

  initial begin
    bit got;
    int lat, bcnt;
    bit dbz;
    bit saw_valid;

    vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFA, 5'd5,  32'hFFFFFFD6, 1'b0};
    vecs[1]  = '{1'b0, 32'h00010000,  32'h00010000, 5'd6,  32'h00000000, 1'b1};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF,  32'h80000000, 5'd7,  32'h00000000, 1'b1};
    vecs[3]  = '{1'b1, 32'hFFFFFF9C,  32'd7,        5'd8,  32'hFFFFFFF2, 1'b0};
    vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 5'd9,  32'h00000000, 1'b1};
    vecs[5]  = '{1'b1, 32'd5,         32'd0,        5'd10, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b0, 32'h7FFFFFFF,  32'd1,        5'd11, 32'h7FFFFFFF, 1'b0};
    vecs[7]  = '{1'b0, 32'hFFFF0000,  32'h00008000, 5'd12, 32'h80000000, 1'b0};
    vecs[8]  = '{1'b1, 32'd100,       32'hFFFFFFF9, 5'd13, 32'hFFFFFFF2, 1'b0};
    vecs[9]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 5'd14, 32'h00000003, 1'b0};
    vecs[10] = '{1'b0, 32'd12345,     32'd0,        5'd15, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 32'h80000000,  32'd1,        5'd16, 32'h80000000, 1'b0};
    vecs[12] = '{1'b1, 32'd3,         32'd7,        5'd17, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 32'hFFFFFFFD,  32'hFFFFFFFB, 5'd31, 32'h0000000F, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0;
    in_instruction = '0;
    in_operand_A = '0;
    in_operand_B = '0;
    result_ack = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset valid", {31'b0, result_valid}, 32'd0);
    checkOutput("reset inflight", inflight_instruction, 32'h0);
    checkOutput("reset data", result_data, 32'h0);
    checkOutput("reset regD", {27'b0, result_regD}, 32'd0);
    checkOutput("reset exc", {31'b0, result_exception}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 14; i++) begin
      dbz = vecs[i].is_div && (vecs[i].b == 32'd0);
      checkOutput($sformatf("v%0d ready", i), {31'b0, in_ready}, 32'd1);
      applyStimulus(vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].rd);
      waitValid(got, lat, bcnt);
      checkOutput($sformatf("v%0d got valid", i), {31'b0, got}, 32'd1);
      checkOutput($sformatf("v%0d latency", i), lat, dbz ? 32'd1 : 32'd34);
      checkOutput($sformatf("v%0d busy cycles", i), bcnt, dbz ? 32'd0 : 32'd33);
      checkOutput($sformatf("v%0d data", i), result_data, vecs[i].exp_data);
      checkOutput($sformatf("v%0d regD", i), {27'b0, result_regD}, {27'b0, vecs[i].rd});
      checkOutput($sformatf("v%0d exc", i), {31'b0, result_exception}, {31'b0, vecs[i].exp_exc});
      checkOutput($sformatf("v%0d inflight", i), inflight_instruction, op_instr(vecs[i].is_div, vecs[i].rd));
      checkOutput($sformatf("v%0d ready in done", i), {31'b0, in_ready}, 32'd0);
      ackResult($sformatf("v%0d", i));
    end

    // Back-to-back: hold the result, then ack and issue a new mul in the same cycle.
    applyStimulus(1'b0, 32'd7, 32'hFFFFFFFA, 5'd5);
    waitValid(got, lat, bcnt);
    checkOutput("b2b first valid", {31'b0, got}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checkOutput($sformatf("b2b hold%0d valid", k), {31'b0, result_valid}, 32'd1);
      checkOutput($sformatf("b2b hold%0d data", k), result_data, 32'hFFFFFFD6);
      checkOutput($sformatf("b2b hold%0d ready", k), {31'b0, in_ready}, 32'd0);
    end
    result_ack     = 1'b1;
    in_valid       = 1'b1;
    in_instruction = op_instr(1'b0, 5'd9);
    in_operand_A   = 32'd3;
    in_operand_B   = 32'd4;
    #1;
    checkOutput("b2b ready with ack", {31'b0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    result_ack = 1'b0;
    in_valid   = 1'b0;
    in_operand_A = 32'hDEADBEEF;
    in_operand_B = 32'h12345678;
    @(negedge clock);
    checkOutput("b2b inflight new", inflight_instruction, op_instr(1'b0, 5'd9));
    checkOutput("b2b valid dropped", {31'b0, result_valid}, 32'd0);
    checkOutput("b2b busy", {31'b0, busy}, 32'd1);
    checkOutput("b2b old data kept", result_data, 32'hFFFFFFD6);
    checkOutput("b2b old regD kept", {27'b0, result_regD}, 32'd5);
    waitValid(got, lat, bcnt);
    checkOutput("b2b second valid", {31'b0, got}, 32'd1);
    checkOutput("b2b second latency", lat, 32'd33);
    checkOutput("b2b second data", result_data, 32'd12);
    checkOutput("b2b second regD", {27'b0, result_regD}, 32'd9);
    checkOutput("b2b second exc", {31'b0, result_exception}, 32'd0);
    ackResult("b2b");

    // Reset during RUN aborts the operation without a result.
    applyStimulus(1'b0, 32'd7, 32'hFFFFFFFA, 5'd5);
    repeat (10) @(negedge clock);
    checkOutput("abort busy before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort ready", {31'b0, in_ready}, 32'd1);
    checkOutput("abort valid", {31'b0, result_valid}, 32'd0);
    checkOutput("abort inflight", inflight_instruction, 32'h0);
    checkOutput("abort data", result_data, 32'h0);
    checkOutput("abort regD", {27'b0, result_regD}, 32'd0);
    checkOutput("abort exc", {31'b0, result_exception}, 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (result_valid) saw_valid = 1'b1;
    end
    checkOutput("abort no result", {31'b0, saw_valid}, 32'd0);

    // Illegal encodings with in_valid are ignored.
    in_valid       = 1'b1;
    in_instruction = mk_instr(5'b00000, 5'd3, 5'b00000);
    in_operand_A   = 32'd1;
    in_operand_B   = 32'd2;
    #1;
    checkOutput("illegal add ready", {31'b0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    in_instruction = mk_instr(5'b00001, 5'd4, 5'b00110);
    @(negedge clock);
    checkOutput("illegal add busy", {31'b0, busy}, 32'd0);
    checkOutput("illegal add inflight", inflight_instruction, 32'h0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    checkOutput("illegal opcode busy", {31'b0, busy}, 32'd0);
    checkOutput("illegal opcode ready", {31'b0, in_ready}, 32'd1);
    checkOutput("illegal opcode valid", {31'b0, result_valid}, 32'd0);
    checkOutput("illegal opcode inflight", inflight_instruction, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
